// File: rtl/cd_rx_des_gen.sv
// ---------------------------------------------------------------------------
// cd_rx_des_gen
//  Parametrised CDBUS/UART-style receive deserialiser. It sits after the rx
//  synchroniser and before the rx frame/CRC logic. It provides:
//  - a configurable data width and runtime parity
//  - 3-sample majority voting at the bit centre, with false-start rejection
//  - bus-idle detection
//  - dual-rate operation: the first character of a frame runs at div_ls and
//    later characters run at div_hs
//  - break and framing-error detection
//
// Parameters
//  DATA_BITS  data bits per character (5..16), LSB first
//  DIV_W      width of div_ls / div_hs
//  IDLE_W     width of idle_wait_len and the idle counter
//  MAJORITY   1: majority of three samples around the centre, 0: single sample
//
// Ports
//  clk, reset_n     system clock, async active-low reset
//  div_ls, div_hs   bit period minus one for low/high speed (clamped to >= 4)
//  idle_wait_len    high bit periods (div_ls) needed to declare the bus idle
//  parity_mode      00/11 none, 01 even, 10 odd (latched at start detection)
//  force_wait_idle  abort whatever is in progress and go to WAIT_IDLE
//  rx               synchronised receive line
//  bus_idle         high while in BUS_IDLE
//  data             last accepted character, valid with data_clk
//  data_clk         1-clk pulse, character accepted
//  parity_err       qualifies data_clk, parity mismatch
//  rx_break         1-clk pulse, break received
//  bit_err          1-clk pulse, framing error
//  glitch           1-clk pulse, false start bit rejected
//  bit_clk, bit_dat 1-clk pulse per data bit plus the sampled value (CRC feed)
// ---------------------------------------------------------------------------
module cd_rx_des_gen #(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16,
   parameter int IDLE_W    = 8,
   parameter int MAJORITY  = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DIV_W-1:0]     div_ls,
   input  logic [DIV_W-1:0]     div_hs,
   input  logic [IDLE_W-1:0]    idle_wait_len,
   input  logic [1:0]           parity_mode,
   input  logic                 force_wait_idle,
   input  logic                 rx,
   output logic                 bus_idle,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_clk,
   output logic                 parity_err,
   output logic                 rx_break,
   output logic                 bit_err,
   output logic                 glitch,
   output logic                 bit_clk,
   output logic                 bit_dat
);

   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
   localparam logic [2:0] ST_BUS_IDLE  = 3'd1;
   localparam logic [2:0] ST_WAIT_DATA = 3'd2;
   localparam logic [2:0] ST_START     = 3'd3;
   localparam logic [2:0] ST_DATA      = 3'd4;
   localparam logic [2:0] ST_PARITY    = 3'd5;
   localparam logic [2:0] ST_STOP      = 3'd6;

   logic [2:0]           state;
   logic [DIV_W-1:0]     cnt;
   logic [DIV_W-1:0]     cur_div;
   logic [DIV_W-1:0]     idle_tmr;
   logic [IDLE_W-1:0]    idle_cnt;
   logic                 first;
   logic                 par_en;
   logic                 par_odd;
   logic                 par_bit;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 vote0;
   logic                 vote1;

   logic [DIV_W-1:0]     ls_eff;
   logic [DIV_W-1:0]     hs_eff;
   logic [DIV_W-1:0]     half;
   logic [DIV_W-1:0]     half_m1;
   logic [DIV_W-1:0]     half_p1;
   logic                 samp_en;
   logic                 samp_val;
   logic                 vote;
   logic                 idle_full;
   logic                 par_exp;
   logic                 is_break;
   logic [DIV_W-1:0]     idle_tmr_nx;
   logic [IDLE_W-1:0]    idle_cnt_nx;

   // Very short periods leave no room for the three centre samples, so
   // dividers below 4 are clamped to 4.
   assign ls_eff  = (div_ls < DIV_W'(4)) ? DIV_W'(4) : div_ls;
   assign hs_eff  = (div_hs < DIV_W'(4)) ? DIV_W'(4) : div_hs;

   // With majority voting the decision lands one clock after the centre,
   // when the third sample (half+1) is the live rx value.
   assign half    = cur_div >> 1;
   assign half_m1 = half - DIV_W'(1);
   assign half_p1 = half + DIV_W'(1);
   assign vote    = (vote0 & vote1) | (vote0 & rx) | (vote1 & rx);
   assign samp_en  = (MAJORITY != 0) ? (cnt == half_p1) : (cnt == half);
   assign samp_val = (MAJORITY != 0) ? vote : rx;

   assign idle_full = (idle_cnt >= idle_wait_len);
   assign par_exp   = (^shreg) ^ par_odd;
   assign is_break  = (shreg == '0) && (!par_en || !par_bit);
   assign bus_idle  = (state == ST_BUS_IDLE);

   // Idle measurement always runs on the low-speed period. A low line restarts
   // it, and the count saturates instead of wrapping.
   always_comb begin
      idle_cnt_nx = idle_cnt;
      idle_tmr_nx = idle_tmr;
      if (!rx) begin
         idle_cnt_nx = '0;
         idle_tmr_nx = '0;
      end else if (idle_tmr >= ls_eff) begin
         idle_tmr_nx = '0;
         if (idle_cnt != '1) begin
            idle_cnt_nx = idle_cnt + IDLE_W'(1);
         end
      end else begin
         idle_tmr_nx = idle_tmr + DIV_W'(1);
      end
   end

   // Main receive sequencer. Status outputs are one-clock pulses registered on
   // the sample edge. The divider and parity mode are latched at the start
   // edge, so changes made mid-character are ignored until the next start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_WAIT_IDLE;
         cnt        <= '0;
         cur_div    <= '0;
         idle_tmr   <= '0;
         idle_cnt   <= '0;
         first      <= 1'b0;
         par_en     <= 1'b0;
         par_odd    <= 1'b0;
         par_bit    <= 1'b0;
         bit_idx    <= '0;
         shreg      <= '0;
         vote0      <= 1'b0;
         vote1      <= 1'b0;
         data       <= '0;
         data_clk   <= 1'b0;
         parity_err <= 1'b0;
         rx_break   <= 1'b0;
         bit_err    <= 1'b0;
         glitch     <= 1'b0;
         bit_clk    <= 1'b0;
         bit_dat    <= 1'b0;
      end else begin
         data_clk   <= 1'b0;
         parity_err <= 1'b0;
         rx_break   <= 1'b0;
         bit_err    <= 1'b0;
         glitch     <= 1'b0;
         bit_clk    <= 1'b0;

         if (force_wait_idle) begin
            state    <= ST_WAIT_IDLE;
            idle_cnt <= '0;
            idle_tmr <= '0;
         end else begin
            case (state)
               ST_WAIT_IDLE: begin
                  if (idle_full) begin
                     state <= ST_BUS_IDLE;
                  end else begin
                     idle_cnt <= idle_cnt_nx;
                     idle_tmr <= idle_tmr_nx;
                  end
               end

               ST_BUS_IDLE: begin
                  if (!rx) begin
                     state   <= ST_START;
                     cnt     <= '0;
                     cur_div <= ls_eff;
                     first   <= 1'b1;
                     par_en  <= ^parity_mode;
                     par_odd <= parity_mode[1];
                  end
               end

               ST_WAIT_DATA: begin
                  if (!rx) begin
                     state   <= ST_START;
                     cnt     <= '0;
                     cur_div <= hs_eff;
                     first   <= 1'b0;
                     par_en  <= ^parity_mode;
                     par_odd <= parity_mode[1];
                  end else if (idle_full) begin
                     state <= ST_BUS_IDLE;
                  end else begin
                     idle_cnt <= idle_cnt_nx;
                     idle_tmr <= idle_tmr_nx;
                  end
               end

               ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                  cnt <= (cnt >= cur_div) ? '0 : cnt + DIV_W'(1);
                  if (cnt == half_m1) vote0 <= rx;
                  if (cnt == half)    vote1 <= rx;

                  if (samp_en) begin
                     case (state)
                        ST_START: begin
                           if (samp_val) begin
                              glitch <= 1'b1;
                              state  <= first ? ST_BUS_IDLE : ST_WAIT_DATA;
                           end else begin
                              state   <= ST_DATA;
                              bit_idx <= '0;
                           end
                        end
                        ST_DATA: begin
                           shreg   <= {samp_val, shreg[DATA_BITS-1:1]};
                           bit_clk <= 1'b1;
                           bit_dat <= samp_val;
                           if (bit_idx == LAST_IDX) begin
                              state <= par_en ? ST_PARITY : ST_STOP;
                           end else begin
                              bit_idx <= bit_idx + IDX_W'(1);
                           end
                        end
                        ST_PARITY: begin
                           par_bit <= samp_val;
                           state   <= ST_STOP;
                        end
                        default: begin
                           // Leaving at mid-stop lets a next start edge
                           // that arrives early still be caught.
                           idle_cnt <= '0;
                           idle_tmr <= '0;
                           if (samp_val) begin
                              data       <= shreg;
                              data_clk   <= 1'b1;
                              parity_err <= par_en && (par_bit != par_exp);
                              state      <= ST_WAIT_DATA;
                           end else begin
                              if (is_break) begin
                                 rx_break <= 1'b1;
                              end else begin
                                 bit_err <= 1'b1;
                              end
                              state <= ST_WAIT_IDLE;
                           end
                        end
                     endcase
                  end
               end

               default: state <= ST_WAIT_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cd_rx_des_gen.sv
// ---------------------------------------------------------------------------
// tb_cd_rx_des_gen
//  Bench for cd_rx_des_gen (DATA_BITS=8, MAJORITY=1). Characters are built
//  from value/parity/stop choices. Expected data, parity errors,
//  break/framing results and the data bit stream are computed from those
//  choices.
// ---------------------------------------------------------------------------
module tb_cd_rx_des_gen;

   localparam int DATA_BITS = 8;
   localparam int DIV_W     = 16;
   localparam int IDLE_W    = 8;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [DIV_W-1:0]     div_ls = 16'd9;
   logic [DIV_W-1:0]     div_hs = 16'd4;
   logic [IDLE_W-1:0]    idle_wait_len = 8'd10;
   logic [1:0]           parity_mode = 2'b00;
   logic                 force_wait_idle = 1'b0;
   logic                 rx = 1'b1;
   logic                 bus_idle;
   logic [DATA_BITS-1:0] data;
   logic                 data_clk;
   logic                 parity_err;
   logic                 rx_break;
   logic                 bit_err;
   logic                 glitch;
   logic                 bit_clk;
   logic                 bit_dat;

   cd_rx_des_gen #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W), .IDLE_W(IDLE_W), .MAJORITY(1)) dut (
      .clk(clk), .reset_n(reset_n), .div_ls(div_ls), .div_hs(div_hs),
      .idle_wait_len(idle_wait_len), .parity_mode(parity_mode),
      .force_wait_idle(force_wait_idle), .rx(rx), .bus_idle(bus_idle),
      .data(data), .data_clk(data_clk), .parity_err(parity_err),
      .rx_break(rx_break), .bit_err(bit_err), .glitch(glitch),
      .bit_clk(bit_clk), .bit_dat(bit_dat)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [DATA_BITS-1:0] dq[$];
   logic                 pq[$];
   logic                 bq[$];
   int                   n_break = 0;
   int                   n_biterr = 0;
   int                   n_glitch = 0;
   int                   n_excl = 0;
   int                   n_force_pulses = 0;
   logic                 after_force = 1'b0;

   logic [DATA_BITS-1:0] fr_val[4];
   logic                 fr_pbit[4];
   logic                 fr_last_stop;
   int                   fr_n;
   logic [1:0]           fr_pmode;
   int                   fr_gap_max;

   // Outputs are collected on the falling edge, away from the register updates.
   always @(negedge clk) begin
      if (reset_n) begin
         if (data_clk) begin
            dq.push_back(data);
            pq.push_back(parity_err);
         end
         if (bit_clk) bq.push_back(bit_dat);
         n_break  += int'(rx_break);
         n_biterr += int'(bit_err);
         n_glitch += int'(glitch);
         if (int'(data_clk) + int'(rx_break) + int'(bit_err) > 1) n_excl++;
         if (after_force)
            n_force_pulses += int'(data_clk) + int'(rx_break) + int'(bit_err) + int'(glitch) + int'(bit_clk);
      end
   end

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int periodOf(input logic [DIV_W-1:0] d);
      return ((d < 4) ? 4 : int'(d)) + 1;
   endfunction

   // Parity bit that makes the character correct for the given mode.
   function automatic logic goodParity(input logic [DATA_BITS-1:0] v, input logic [1:0] pm);
      logic odd_ones;
      odd_ones = ($countones(v) % 2) == 1;
      return (pm == 2'b01) ? odd_ones : !odd_ones;
   endfunction

   task automatic idleClocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic driveBit(input logic b, input int period);
      rx = b;
      idleClocks(period);
   endtask

   task automatic applyStimulus(input logic [DATA_BITS-1:0] val, input int period,
                                input logic par_en, input logic par_bit, input logic stop_bit);
      driveBit(1'b0, period);
      for (int i = 0; i < DATA_BITS; i++) driveBit(val[i], period);
      if (par_en) driveBit(par_bit, period);
      driveBit(stop_bit, period);
      rx = 1'b1;
   endtask

   task automatic clearMonitor();
      dq.delete();
      pq.delete();
      bq.delete();
      n_break  = 0;
      n_biterr = 0;
      n_glitch = 0;
   endtask

   task automatic waitBusIdle(input string tag);
      int n;
      n = 0;
      while (!bus_idle && n < 1000) begin
         idleClocks(1);
         n++;
      end
      checkOutput(tag, {31'd0, bus_idle}, 32'd1);
   endtask

   // Sends the frame held in fr_* and checks every reported result against
   // what the character choices imply.
   task automatic runFrame(input string tag);
      logic par_en;
      logic stop;
      int   n_good;
      int   exp_break;
      int   exp_biterr;
      int   k;
      parity_mode = fr_pmode;
      par_en = (fr_pmode == 2'b01) || (fr_pmode == 2'b10);
      clearMonitor();
      for (int i = 0; i < fr_n; i++) begin
         stop = (i == fr_n - 1) ? fr_last_stop : 1'b1;
         applyStimulus(fr_val[i], (i == 0) ? periodOf(div_ls) : periodOf(div_hs), par_en, fr_pbit[i], stop);
         if (i < fr_n - 1 && fr_gap_max > 0) idleClocks($urandom_range(0, fr_gap_max));
      end
      waitBusIdle({tag, "_idle"});

      n_good     = fr_last_stop ? fr_n : fr_n - 1;
      exp_break  = 0;
      exp_biterr = 0;
      if (!fr_last_stop) begin
         if (fr_val[fr_n-1] == '0 && (!par_en || !fr_pbit[fr_n-1])) exp_break = 1;
         else exp_biterr = 1;
      end
      checkOutput({tag, "_ndata"}, dq.size(), n_good);
      for (int i = 0; i < n_good; i++) begin
         if (i < dq.size()) begin
            checkOutput($sformatf("%s_data%0d", tag, i), {24'd0, dq[i]}, {24'd0, fr_val[i]});
            checkOutput($sformatf("%s_perr%0d", tag, i), {31'd0, pq[i]},
                        {31'd0, par_en && (fr_pbit[i] != goodParity(fr_val[i], fr_pmode))});
         end
      end
      checkOutput({tag, "_break"}, n_break, exp_break);
      checkOutput({tag, "_biterr"}, n_biterr, exp_biterr);
      checkOutput({tag, "_glitch"}, n_glitch, 0);
      checkOutput({tag, "_nbits"}, bq.size(), fr_n * DATA_BITS);
      k = 0;
      for (int i = 0; i < fr_n; i++) begin
         for (int b = 0; b < DATA_BITS; b++) begin
            if (k < bq.size())
               checkOutput($sformatf("%s_bit%0d", tag, k), {31'd0, bq[k]}, {31'd0, fr_val[i][b]});
            k++;
         end
      end
   endtask

   initial begin
      fr_gap_max = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_flags", {24'd0, bus_idle, data_clk, parity_err, rx_break, bit_err, glitch, bit_clk, bit_dat}, 32'd0);
      checkOutput("reset_data", {24'd0, data}, 32'd0);
      reset_n = 1'b1;

      // The bus becomes idle 10 low-speed periods plus one clock after reset.
      idleClocks(100);
      checkOutput("idle_before_101", {31'd0, bus_idle}, 32'd0);
      idleClocks(1);
      checkOutput("idle_at_101", {31'd0, bus_idle}, 32'd1);

      // Dual-rate two-character frame, 8N1.
      fr_pmode = 2'b00; fr_n = 2; fr_last_stop = 1'b1;
      fr_val[0] = 8'h55; fr_val[1] = 8'hA3; fr_pbit[0] = 1'b0; fr_pbit[1] = 1'b0;
      runFrame("dual");

      // Even parity on 0x07: a parity bit of 0 is wrong and 1 is right.
      fr_pmode = 2'b01; fr_n = 2; fr_last_stop = 1'b1;
      fr_val[0] = 8'h07; fr_val[1] = 8'h07; fr_pbit[0] = 1'b0; fr_pbit[1] = 1'b1;
      runFrame("par");

      // A two-clock low pulse from bus idle is rejected as a glitch.
      parity_mode = 2'b00;
      clearMonitor();
      rx = 1'b0;
      idleClocks(2);
      rx = 1'b1;
      idleClocks(20);
      checkOutput("glitch_pulse", n_glitch, 1);
      checkOutput("glitch_ndata", dq.size(), 0);
      checkOutput("glitch_nbits", bq.size(), 0);
      checkOutput("glitch_idle", {31'd0, bus_idle}, 32'd1);

      // The line is held low for 12 bit periods, giving a break.
      clearMonitor();
      rx = 1'b0;
      idleClocks(12 * periodOf(div_ls));
      rx = 1'b1;
      idleClocks(95);
      checkOutput("brk_idle_early", {31'd0, bus_idle}, 32'd0);
      waitBusIdle("brk_idle");
      checkOutput("brk_pulse", n_break, 1);
      checkOutput("brk_biterr", n_biterr, 0);
      checkOutput("brk_ndata", dq.size(), 0);
      checkOutput("brk_nbits", bq.size(), DATA_BITS);

      // A stop bit of 0 with nonzero data is a framing error.
      fr_pmode = 2'b00; fr_n = 1; fr_last_stop = 1'b0;
      fr_val[0] = 8'h12; fr_pbit[0] = 1'b0;
      runFrame("berr");

      // force_wait_idle is raised in the middle of the data bits.
      clearMonitor();
      driveBit(1'b0, periodOf(div_ls));
      driveBit(1'b1, periodOf(div_ls));
      driveBit(1'b0, periodOf(div_ls));
      driveBit(1'b1, periodOf(div_ls));
      rx = 1'b0;
      idleClocks(1);
      force_wait_idle = 1'b1;
      rx = 1'b1;
      idleClocks(1);
      force_wait_idle = 1'b0;
      after_force = 1'b1;
      checkOutput("force_state", {31'd0, bus_idle}, 32'd0);
      idleClocks(90);
      checkOutput("force_idle_early", {31'd0, bus_idle}, 32'd0);
      waitBusIdle("force_idle");
      after_force = 1'b0;
      checkOutput("force_pulses", n_force_pulses, 0);
      checkOutput("force_ndata", dq.size(), 0);

      // Random frames with random dividers, parity modes and error injection.
      fr_gap_max = 6;
      for (int f = 0; f < 20; f++) begin
         div_ls   = DIV_W'($urandom_range(8, 15));
         div_hs   = DIV_W'($urandom_range(2, 7));
         fr_pmode = 2'($urandom_range(0, 3));
         fr_n     = $urandom_range(1, 3);
         fr_last_stop = ($urandom_range(0, 4) != 0);
         for (int i = 0; i < fr_n; i++) begin
            fr_val[i]  = ($urandom_range(0, 5) == 0) ? '0 : DATA_BITS'($urandom);
            fr_pbit[i] = goodParity(fr_val[i], fr_pmode);
            if ($urandom_range(0, 3) == 0) fr_pbit[i] = !fr_pbit[i];
         end
         runFrame($sformatf("rnd%0d", f));
      end

      checkOutput("exclusive_pulses", n_excl, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
